file_locator: RTL

//  Downstream of the FAT directory-entry parser. Compares each parsed entry (fready pulse) to a target name.
//  On match, converts the file's first cluster to an LBA and issues one read request per 512-B sector.

---
 rtl/fat_pkg.sv | 36 +++
 rtl/file_locator_if.sv | 23 ++
 rtl/file_locator_name_cmp.sv | 23 ++
 rtl/file_locator.sv | 156 +++++++++++++++
 4 files changed

// File: rtl/fat_pkg.sv
// Shared FAT-reader definitions: geometry constants, name storage type,
// locator state encoding and small arithmetic helpers.
package fat_pkg;

  localparam int NAME_MAX     = 52;
  localparam int SEC_LOG2     = 9;
  localparam int MAX_SPC_LOG2 = 7;

  typedef logic [NAME_MAX-1:0][7:0] fname_t;

  typedef enum logic [2:0] {
    IDLE,
    SCAN,
    CALC,
    ISSUE,
    WAIT,
    DONE,
    FAIL
  } loc_state_e;

  // Oversized cluster shifts saturate at the largest supported cluster size.
  function automatic logic [2:0] clamp_spc(input logic [2:0] spc);
    if (spc >= 3'(MAX_SPC_LOG2)) begin
      return 3'(MAX_SPC_LOG2);
    end
    return spc;
  endfunction

  // Round up to whole sectors; the carry bit keeps 0xFFFFFFFF from wrapping.
  function automatic logic [23:0] bytes_to_sectors(input logic [31:0] nbytes);
    logic [32:0] sum;
    sum = {1'b0, nbytes} + 33'((1 << SEC_LOG2) - 1);
    return 24'(sum >> SEC_LOG2);
  endfunction

endpackage

// File: rtl/file_locator_if.sv
// Sector-read request channel between the locator and the SD sector reader.
interface file_locator_if;

  logic        rd_req;
  logic [31:0] rd_lba;
  logic        rd_ack;
  logic        rd_done;

  modport master (
    output rd_req,
    output rd_lba,
    input  rd_ack,
    input  rd_done
  );

  modport slave (
    input  rd_req,
    input  rd_lba,
    output rd_ack,
    output rd_done
  );

endinterface

// File: rtl/file_locator_name_cmp.sv
// Combinational name equality: lengths equal, non-empty, and every byte
// below the target length identical.
module name_cmp
  import fat_pkg::*;
(
  input  logic [7:0] len_a,
  input  fname_t     name_a,
  input  logic [7:0] len_b,
  input  fname_t     name_b,
  output logic       match
);

  logic [NAME_MAX-1:0] byte_ok;

  generate
    for (genvar gi = 0; gi < NAME_MAX; gi++) begin : g_byte
      assign byte_ok[gi] = (8'(gi) >= len_b) || (name_a[gi] == name_b[gi]);
    end
  endgenerate

  assign match = (len_a == len_b) && (len_b != 8'd0) && (&byte_ok);

endmodule

// File: rtl/file_locator.sv
// Matches parsed directory entries against a target name and streams
// sector read requests covering the matched file's contiguous clusters.
module file_locator
  import fat_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             scan_start,
  input  logic             scan_done,
  input  logic [7:0]       tnamelen,
  input  fname_t           tname,
  input  logic             fready,
  input  logic [7:0]       fnamelen,
  input  fname_t           fname,
  input  logic [15:0]      fcluster,
  input  logic [31:0]      fsize,
  input  logic [31:0]      data_lba,
  input  logic [2:0]       spc_log2,
  file_locator_if.master   rd,
  output logic             busy,
  output logic             found,
  output logic             finished,
  output logic             not_found,
  output logic [31:0]      file_size,
  output logic [23:0]      sec_left
);

  loc_state_e  state_q, state_d;
  logic [15:0] cluster_q, cluster_d;
  logic [31:0] size_q, size_d;
  logic [31:0] lba_q, lba_d;
  logic [23:0] sec_left_q, sec_left_d;
  logic        found_q, found_d;
  logic        finished_q, finished_d;
  logic        not_found_q, not_found_d;

  logic        name_match;
  logic [2:0]  spc_eff;
  logic [31:0] first_lba;

  name_cmp u_name_cmp (
    .len_a  (fnamelen),
    .name_a (fname),
    .len_b  (tnamelen),
    .name_b (tname),
    .match  (name_match)
  );

  assign spc_eff   = clamp_spc(spc_log2);
  // Cluster numbering starts at 2; the sum wraps modulo 2^32.
  assign first_lba = data_lba + (32'(cluster_q - 16'd2) << spc_eff);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cluster_q   <= '0;
      size_q      <= '0;
      lba_q       <= '0;
      sec_left_q  <= '0;
      found_q     <= 1'b0;
      finished_q  <= 1'b0;
      not_found_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cluster_q   <= cluster_d;
      size_q      <= size_d;
      lba_q       <= lba_d;
      sec_left_q  <= sec_left_d;
      found_q     <= found_d;
      finished_q  <= finished_d;
      not_found_q <= not_found_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cluster_d   = cluster_q;
    size_d      = size_q;
    lba_d       = lba_q;
    sec_left_d  = sec_left_q;
    found_d     = 1'b0;
    finished_d  = 1'b0;
    not_found_d = 1'b0;

    unique case (state_q)
      IDLE, DONE, FAIL: begin
        if (scan_start) begin
          state_d = SCAN;
        end
      end

      SCAN: begin
        // A match arriving together with scan_done takes priority.
        if (fready && name_match) begin
          cluster_d = fcluster;
          size_d    = fsize;
          found_d   = 1'b1;
          state_d   = CALC;
        end else if (scan_done) begin
          not_found_d = 1'b1;
          state_d     = FAIL;
        end
      end

      CALC: begin
        if (cluster_q < 16'd2) begin
          not_found_d = 1'b1;
          state_d     = FAIL;
        end else if (size_q == 32'd0) begin
          finished_d = 1'b1;
          state_d    = DONE;
        end else begin
          lba_d      = first_lba;
          sec_left_d = bytes_to_sectors(size_q);
          state_d    = ISSUE;
        end
      end

      ISSUE: begin
        // A simultaneous rd_done belongs to no outstanding request and is dropped.
        if (rd.rd_ack) begin
          sec_left_d = sec_left_q - 24'd1;
          state_d    = WAIT;
        end
      end

      WAIT: begin
        if (rd.rd_done) begin
          if (sec_left_q == 24'd0) begin
            finished_d = 1'b1;
            state_d    = DONE;
          end else begin
            lba_d   = lba_q + 32'd1;
            state_d = ISSUE;
          end
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Decoded from state so an asynchronous reset withdraws the request at once.
  assign rd.rd_req = (state_q == ISSUE);
  assign rd.rd_lba = lba_q;

  assign busy      = (state_q != IDLE) && (state_q != DONE) && (state_q != FAIL);
  assign found     = found_q;
  assign finished  = finished_q;
  assign not_found = not_found_q;
  assign file_size = size_q;
  assign sec_left  = sec_left_q;

endmodule
